// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, boot hold, halt on BREAK/error,
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter int                   WORD_SIZE     = 32,
  parameter int                   INST_MEM_SIZE = 256,
  parameter logic [WORD_SIZE-1:0] RESET_PC      = '0,
  parameter int                   BOOT_CYCLES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_target,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_data,
  output logic [WORD_SIZE-1:0] ifid_instr,
  output logic [WORD_SIZE-1:0] ifid_pc4,
  output logic                 ifid_valid,
  output logic                 halted,
  output logic                 addr_err
);

  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BOOT_CYCLES - 1);
  localparam logic [WORD_SIZE-1:0] MEM_WORDS = WORD_SIZE'(INST_MEM_SIZE);
  localparam logic [WORD_SIZE-1:0] LAST_IDX = WORD_SIZE'(INST_MEM_SIZE - 1);
  localparam logic [WORD_SIZE-1:0] BREAK_W = WORD_SIZE'(32'h0000_000D);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   pc_q, pc_d;
  logic [WORD_SIZE-1:0]   instr_q, instr_d;
  logic [WORD_SIZE-1:0]   pc4_q, pc4_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic [WORD_SIZE-1:0]   pc_plus4;
  logic [WORD_SIZE-1:0]   pc_idx;
  logic [WORD_SIZE-1:0]   tgt_idx;
  logic                   tgt_bad;
  logic                   last_word;
  logic                   is_break;

  assign pc_plus4  = pc_q + WORD_SIZE'(4);
  assign pc_idx    = {2'b00, pc_q[WORD_SIZE-1:2]};
  assign tgt_idx   = {2'b00, redirect_target[WORD_SIZE-1:2]};
  assign tgt_bad   = (redirect_target[1:0] != 2'b00) || (tgt_idx >= MEM_WORDS);
  assign last_word = (pc_idx == LAST_IDX);
  assign is_break  = (imem_data == BREAK_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;
    unique case (state_q)
      S_BOOT: begin
        pc_d    = RESET_PC;
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (redirect) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (tgt_bad) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d = redirect_target;
          end
        end else if (flush) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (!stall) pc_d = pc_plus4;
        end else if (!stall) begin
          instr_d = imem_data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          // BREAK or end of memory: keep the word, freeze pc here
          if (is_break || last_word) begin
            state_d = S_HALT;
            err_d   = err_q | last_word;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      S_HALT: begin
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_BOOT;
        cnt_d   = '0;
        pc_d    = RESET_PC;
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    imem_addr  = pc_idx;
    ifid_instr = instr_q;
    ifid_pc4   = pc4_q;
    ifid_valid = valid_q;
    halted     = (state_q == S_HALT);
    addr_err   = err_q;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter WORD_SIZE, default 32, data/address width.
REQ-002 Parameter INST_MEM_SIZE, default 256, instruction memory depth in words.
REQ-003 Parameter RESET_PC, default 0, byte address of first fetch, word-aligned.
REQ-004 Parameter BOOT_CYCLES, default 2, clocks held in BOOT after reset release.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 stall  in  1  hold PC and IF/ID register.
REQ-008 flush  in  1  load bubble into IF/ID register.
REQ-009 redirect  in  1  branch/jump taken; load redirect_target into PC.
REQ-010 redirect_target  in  WORD_SIZE  byte address of next fetch.
REQ-011 imem_addr  out  WORD_SIZE  word index to instruction memory, {2'b00, pc[WORD_SIZE-1:2]}, combinational from PC.
REQ-012 imem_data  in  WORD_SIZE  instruction word, asynchronous read of imem_addr, valid same cycle.
REQ-013 ifid_instr  out  WORD_SIZE  registered instruction for decode.
REQ-014 ifid_pc4  out  WORD_SIZE  registered PC+4 of ifid_instr.
REQ-015 ifid_valid  out  1  ifid_instr is a real instruction, not a bubble.
REQ-016 halted  out  1  block in HALTED state.
REQ-017 addr_err  out  1  sticky, misaligned or out-of-range fetch address.

Function
REQ-018 States SHALL be BOOT, RUN, HALTED; reset enters BOOT.
REQ-019 BOOT: PC held at RESET_PC, IF/ID bubble, all inputs ignored; after exactly BOOT_CYCLES rising edges go to RUN.
REQ-020 Bubble SHALL mean ifid_valid=0, ifid_instr=0, ifid_pc4=0.
REQ-021 RUN priority per edge: redirect > flush > stall > normal advance.
REQ-022 redirect, legal target: pc<=redirect_target, IF/ID<=bubble, even if stall=1.
REQ-023 redirect, target[1:0]!=0 or target>>2 >= INST_MEM_SIZE: pc unchanged, IF/ID<=bubble, addr_err<=1, state<=HALTED.
REQ-024 flush without redirect: IF/ID<=bubble; pc holds if stall=1, else pc<=pc+4.
REQ-025 stall alone: pc, ifid_instr, ifid_pc4, ifid_valid all hold.
REQ-026 Normal advance: ifid_instr<=imem_data, ifid_pc4<=pc+4, ifid_valid<=1, pc<=pc+4; fetch-to-IF/ID latency one clock.
REQ-027 Normal advance capturing imem_data==32'h0000000D (BREAK): instruction captured valid, pc held, state<=HALTED.
REQ-028 Normal advance from last word (pc>>2==INST_MEM_SIZE-1): instruction captured valid, pc held, addr_err<=1, state<=HALTED.
REQ-029 HALTED: pc frozen, IF/ID<=bubble on every edge, all inputs ignored; exit only via rst.
REQ-030 halted SHALL be registered state decode, asserted from the edge entering HALTED.
REQ-031 PC arithmetic SHALL be unsigned WORD_SIZE-bit; pc[1:0] SHALL always be 0.

Reset
REQ-032 rst=1 SHALL immediately, without clock, set pc=RESET_PC, state=BOOT, boot counter=0, ifid_instr=0, ifid_pc4=0, ifid_valid=0, halted=0, addr_err=0.
REQ-033 rst asserted mid-operation, including during stall or HALTED, SHALL discard all state; behaviour after release identical to power-up.
REQ-034 imem_addr SHALL equal RESET_PC>>2 while rst=1.

Verification
REQ-035 Boot: release rst, memory words 0..3 = 0x11,0x22,0x33,0x44 -> ifid_valid=0 for 2 edges, then ifid_instr 0x11,0x22,0x33 with ifid_pc4 4,8,12 on successive edges.
REQ-036 Stall/flush: stall=1 for 3 cycles at pc=8 -> IF/ID and imem_addr=2 frozen; stall=1 with flush=1 -> ifid_valid=0, pc stays 8.
REQ-037 Redirect: redirect=1, target=0x40, stall=1 same cycle -> next edge pc=0x40, imem_addr=0x10, ifid_valid=0; following edge ifid_pc4=0x44, valid 1.
REQ-038 Errors: target=0x42 -> addr_err=1, halted=1, pc unchanged; separately target=INST_MEM_SIZE*4 -> same; sequential run to word 255 -> word captured valid, then addr_err=1, halted=1.
REQ-039 BREAK: word 5=0x0000000D -> captured with ifid_valid=1, halted=1, pc=20 frozen, next edge bubble, redirect ignored.
REQ-040 Async reset: assert rst between clock edges while HALTED -> outputs reach reset values before next edge; BOOT restarts from RESET_PC.
